stream_mux4_rr: RTL and testbench
=================================

Name: stream_mux4_rr

Overview:
- Four-lane to one-lane stream multiplexer; the gathering end of the 1-to-4 demux path.
- Uses round-robin arbitration across four valid/ready input channels.
- Drives one registered output channel tagged with the 2-bit source index, so a downstream demux can re-route each word by its tag.
- Sits between four producer lanes and a single shared consumer link.

Parameters:
- WIDTH, 8, data bits per word.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush: drops the held word and restarts arbitration at channel 0.
- in_valid  input  4  per-channel word valid; bit i belongs to channel i.
- in_data  input  4*WIDTH  channel i data on bits [i*WIDTH +: WIDTH].
- in_ready  output  4  per-channel accept, combinational; at most one bit high.
- out_valid  output  1  output word valid (registered).
- out_data  output  WIDTH  output word (registered).
- out_sel  output  2  source channel index of out_data (registered).
- out_ready  input  1  consumer accept.
- busy_cnt  output  8  count of words delivered, wraps 255->0.

Behaviour:
- Reset (rst=1, async): out_valid=0, out_data=0, out_sel=2'b00, busy_cnt=0, last-grant pointer=3 (channel 0 has first priority), state=EMPTY.
- The FSM has two states:
  - EMPTY (out_valid=0).
  - FULL (out_valid=1).
- load = (state==EMPTY) || out_ready. The output register may accept a new word this cycle only when load=1.
- Arbitration (combinational):
  - Search channels starting at ptr+1 mod 4, ascending with wrap.
  - The first channel with in_valid=1 is the grant g.
  - No valid channel means no grant.
- in_ready[i] = load && grant present && (g==i). All bits are 0 otherwise, including while rst or clr is asserted.
- Transfer on clock edge when a grant is present and load=1:
  - out_data <= channel g data.
  - out_sel <= g.
  - out_valid <= 1.
  - ptr <= g.
  - Next state is FULL.
- Consume: out_valid && out_ready completes the output transfer and busy_cnt increments by 1, mod 256.
  - If a new grant exists in the same cycle, the register reloads with no bubble and stays FULL.
  - Otherwise out_valid <= 0 and the next state is EMPTY.
- Stall: while FULL and out_ready=0:
  - out_data and out_sel hold stable.
  - All in_ready bits are 0.
  - ptr does not move.
- Latency: an input word accepted at edge N is presented on the output immediately after edge N (1 cycle). Sustained throughput is 1 word/cycle when out_ready=1.
- Fairness: with all four channels continuously valid, the grant order is 0,1,2,3,0,... Each channel gets 1 of every 4 transfers.
- Single active channel: it is granted every cycle regardless of ptr.
- clr=1 (synchronous, takes priority over transfer):
  - out_valid <= 0 and ptr <= 3.
  - out_data and out_sel hold their values.
  - busy_cnt is unchanged.
  - No input is accepted.
  - The held word is discarded.
- rst asserted mid-transfer: outputs clear immediately (asynchronously) and the held word is lost. Producers must see in_ready=0 while rst=1.
- in_data of non-granted channels is ignored. in_valid may drop without a handshake; the arbiter re-evaluates every cycle.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all in_valid=0 -> out_valid=0, out_sel=00, busy_cnt=0, in_ready=0000.
- Single channel: only ch2 valid with data 8'hA5, out_ready=1 -> in_ready=0100; next cycle out_valid=1, out_data=A5, out_sel=10; busy_cnt=1 after consume.
- Round robin: all in_valid=1, ch i data=8'h10+i, out_ready=1 for 8 cycles -> out_sel sequence 00,01,10,11,00,01,10,11 with data 10,11,12,13 repeating, no bubbles; busy_cnt=8.
- Back-pressure: FULL with out_data=8'h11, out_sel=01, out_ready=0 for 3 cycles -> outputs stable, in_ready=0000; on out_ready=1, next grant is ch2.
- Flush: FULL holding ch3 word, pulse clr=1 for 1 cycle -> out_valid=0 next cycle; with all channels valid afterwards, first out_sel=00.
- Async reset mid-stream: assert rst between clock edges while out_valid=1 -> out_valid and busy_cnt drop to 0 before the next edge; after release, arbitration restarts at ch0.

Source files
------------

// File: rtl/stream_mux4_rr_if.sv
// Handshake bundle for the 4-to-1 round-robin stream mux: four producer lanes in,
// one tagged consumer lane out, plus the delivered-word counter.
interface stream_mux4_rr_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         in_valid;
  logic [4*WIDTH-1:0] in_data;
  logic [3:0]         in_ready;
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_sel;
  logic               out_ready;
  logic [7:0]         busy_cnt;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_sel, busy_cnt
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_sel, busy_cnt
  );
endinterface

// File: rtl/stream_mux4_rr.sv
// Four-lane to one-lane stream multiplexer with round-robin arbitration and a
// registered, source-tagged output stage that sustains one word per cycle.
module stream_mux4_rr #(
  parameter int WIDTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  stream_mux4_rr_if.slave   bus
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic [1:0]       ptr_r;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       sel_r;
  logic [7:0]       cnt_r;

  logic             grant_valid_s;
  logic [1:0]       grant_idx_s;
  logic             load_s;
  logic             take_s;
  logic             consume_s;
  logic [3:0]       in_ready_s;

  // Scan downward so the channel closest after ptr overwrites any farther hit.
  function automatic logic [2:0] rr_pick(input logic [3:0] valid, input logic [1:0] ptr);
    logic [2:0] pick;
    logic [1:0] idx;
    pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + k[1:0];
      if (valid[idx]) begin
        pick = {1'b1, idx};
      end else begin
        pick = pick;
      end
    end
    return pick;
  endfunction

  // Arbitration and handshake qualifiers.
  always_comb begin
    {grant_valid_s, grant_idx_s} = rr_pick(bus.in_valid, ptr_r);
    load_s    = (state_r == EMPTY) || bus.out_ready;
    take_s    = load_s && grant_valid_s && !clr && !rst;
    consume_s = (state_r == FULL) && bus.out_ready && !clr;
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    if (clr) begin
      state_nxt_s = EMPTY;
    end else if (take_s) begin
      state_nxt_s = FULL;
    end else if (consume_s) begin
      state_nxt_s = EMPTY;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Output decode: one-hot accept for the granted lane only.
  always_comb begin
    in_ready_s = 4'b0000;
    if (take_s) begin
      in_ready_s = 4'b0001 << grant_idx_s;
    end else begin
      in_ready_s = 4'b0000;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Output word, tag, pointer and delivered-word counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_r <= '0;
      sel_r  <= 2'b00;
      ptr_r  <= 2'd3;
      cnt_r  <= 8'd0;
    end else if (clr) begin
      ptr_r  <= 2'd3;
    end else begin
      if (take_s) begin
        data_r <= bus.in_data[grant_idx_s*WIDTH +: WIDTH];
        sel_r  <= grant_idx_s;
        ptr_r  <= grant_idx_s;
      end
      if (consume_s) begin
        cnt_r <= cnt_r + 8'd1;
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = (state_r == FULL);
  assign bus.out_data  = data_r;
  assign bus.out_sel   = sel_r;
  assign bus.busy_cnt  = cnt_r;

endmodule

// File: tb/tb_stream_mux4_rr.sv
// Self-checking bench for stream_mux4_rr: hand-derived vector table with a
// scoreboard for the held output word, plus reset and async-reset sequences.
module tb_stream_mux4_rr;
  localparam int WIDTH = 8;
  localparam int NVEC  = 27;

  logic clk = 1'b0;
  logic rst;
  logic clr;

  always #5 clk = ~clk;

  stream_mux4_rr_if #(.WIDTH(WIDTH)) bus ();

  stream_mux4_rr #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .bus (bus)
  );

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] data;
    logic        rdy;
    logic        clr;
    logic [3:0]  exp_ready;
  } vec_t;

  typedef struct {
    logic [1:0] sel;
    logic [7:0] data;
  } word_t;

  vec_t  vecs [NVEC];
  word_t sb [$];
  int    tests = 0;
  int    fails = 0;
  logic [7:0] exp_cnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] onehot_idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 2'd1;
      4'b0100: return 2'd2;
      4'b1000: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  task automatic set_vec(input int i, input logic [3:0] v, input logic [31:0] d,
                         input logic r, input logic c, input logic [3:0] e);
    vecs[i].valid     = v;
    vecs[i].data      = d;
    vecs[i].rdy       = r;
    vecs[i].clr       = c;
    vecs[i].exp_ready = e;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] dd;
    logic [31:0] sa;
    logic [31:0] d;
    word_t       w;

    dd = 32'h13121110;
    sa = 32'h13A51110;

    // Idle, single channel 2, flush to restart at ch0, round robin x8.
    set_vec(0,  4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    set_vec(1,  4'b0100, sa, 1'b1, 1'b0, 4'b0100);
    set_vec(2,  4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    set_vec(3,  4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    set_vec(4,  4'b0000, dd, 1'b1, 1'b1, 4'b0000);
    set_vec(5,  4'b1111, dd, 1'b1, 1'b0, 4'b0001);
    set_vec(6,  4'b1111, dd, 1'b1, 1'b0, 4'b0010);
    set_vec(7,  4'b1111, dd, 1'b1, 1'b0, 4'b0100);
    set_vec(8,  4'b1111, dd, 1'b1, 1'b0, 4'b1000);
    set_vec(9,  4'b1111, dd, 1'b1, 1'b0, 4'b0001);
    set_vec(10, 4'b1111, dd, 1'b1, 1'b0, 4'b0010);
    set_vec(11, 4'b1111, dd, 1'b1, 1'b0, 4'b0100);
    set_vec(12, 4'b1111, dd, 1'b1, 1'b0, 4'b1000);
    set_vec(13, 4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    // Back-pressure holding ch1 word, then release picks ch2.
    set_vec(14, 4'b0010, dd, 1'b1, 1'b0, 4'b0010);
    set_vec(15, 4'b1111, dd, 1'b0, 1'b0, 4'b0000);
    set_vec(16, 4'b1111, dd, 1'b0, 1'b0, 4'b0000);
    set_vec(17, 4'b1111, dd, 1'b0, 1'b0, 4'b0000);
    set_vec(18, 4'b1111, dd, 1'b1, 1'b0, 4'b0100);
    // Load ch3, flush it, then all valid restarts at ch0.
    set_vec(19, 4'b1000, dd, 1'b1, 1'b0, 4'b1000);
    set_vec(20, 4'b1111, dd, 1'b0, 1'b1, 4'b0000);
    set_vec(21, 4'b1111, dd, 1'b1, 1'b0, 4'b0001);
    set_vec(22, 4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    // Lone channel 0 is granted back-to-back even though ptr points at it.
    set_vec(23, 4'b0001, dd, 1'b1, 1'b0, 4'b0001);
    set_vec(24, 4'b0001, dd, 1'b1, 1'b0, 4'b0001);
    set_vec(25, 4'b0000, dd, 1'b1, 1'b0, 4'b0000);
    set_vec(26, 4'b0000, dd, 1'b1, 1'b0, 4'b0000);

    // Reset with all lanes valid: nothing may be accepted.
    rst = 1'b1;
    clr = 1'b0;
    bus.in_valid  = 4'b1111;
    bus.in_data   = dd;
    bus.out_ready = 1'b1;
    exp_cnt = 8'd0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_in_ready",  32'(bus.in_ready),  32'h0);
    check("rst_out_valid", 32'(bus.out_valid), 32'h0);
    check("rst_out_sel",   32'(bus.out_sel),   32'h0);
    check("rst_out_data",  32'(bus.out_data),  32'h0);
    check("rst_busy_cnt",  32'(bus.busy_cnt),  32'h0);
    bus.in_valid = 4'b0000;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus.in_valid  = vecs[i].valid;
      bus.in_data   = vecs[i].data;
      bus.out_ready = vecs[i].rdy;
      clr           = vecs[i].clr;
      #1;
      check($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        check($sformatf("v%0d_out_sel", i),  32'(bus.out_sel),  32'(sb[0].sel));
        check($sformatf("v%0d_out_data", i), 32'(bus.out_data), 32'(sb[0].data));
      end
      check($sformatf("v%0d_busy_cnt", i), 32'(bus.busy_cnt), 32'(exp_cnt));
      check($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].exp_ready));
      if (vecs[i].clr) begin
        sb.delete();
      end else begin
        if (sb.size() != 0 && vecs[i].rdy) begin
          void'(sb.pop_front());
          exp_cnt = exp_cnt + 8'd1;
        end
        if (vecs[i].exp_ready != 4'b0000) begin
          d = vecs[i].data;
          w.sel  = onehot_idx(vecs[i].exp_ready);
          w.data = d[w.sel*8 +: 8];
          sb.push_back(w);
        end
      end
    end

    // Async reset while a word is held: ptr is 0 here so ch1 is granted first.
    clr = 1'b0;
    @(negedge clk);
    bus.in_valid  = 4'b1111;
    bus.in_data   = dd;
    bus.out_ready = 1'b1;
    #1;
    check("pre_rst_in_ready", 32'(bus.in_ready), 32'h2);
    @(negedge clk);
    #1;
    check("pre_rst_out_valid", 32'(bus.out_valid), 32'h1);
    check("pre_rst_out_data",  32'(bus.out_data),  32'h11);
    #2;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(bus.out_valid), 32'h0);
    check("arst_busy_cnt",  32'(bus.busy_cnt),  32'h0);
    check("arst_in_ready",  32'(bus.in_ready),  32'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 32'h1);
    @(negedge clk);
    #1;
    check("post_rst_out_valid", 32'(bus.out_valid), 32'h1);
    check("post_rst_out_sel",   32'(bus.out_sel),   32'h0);
    check("post_rst_out_data",  32'(bus.out_data),  32'h10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
